// File: rtl/handshake_word_tx.sv
// Domain-A serialiser feeding the two-phase handshake synchronizer: one ReqA pulse
// per bit, next bit only after the matching AckA, with sticky protocol/timeout flags.
module handshake_word_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 255
) (
  input  logic             clkA,
  input  logic             rstA,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             DataA,
  output logic             ReqA,
  input  logic             AckA,
  output logic             busy,
  output logic             done,
  output logic             proto_err,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [15:0]   TMAX      = 16'(TIMEOUT);
  localparam logic [15:0]   TMAX_M1   = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, WAIT_ACK} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    bit_cnt;
  logic [15:0]      tcnt;
  logic             load, advance, finish;
  logic             first_load, first_next;
  logic             proto_hit, timeout_hit;

  assign shift_next  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  assign first_load  = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign first_next  = MSB_FIRST ? shift_next[WIDTH-1] : shift_next[0];
  assign proto_hit   = AckA && (state != WAIT_ACK);
  // The flag fires on the step that reaches TIMEOUT, not on every saturated cycle.
  assign timeout_hit = (TIMEOUT != 0) && (state == WAIT_ACK) && (tcnt == TMAX_M1);

  always_comb begin
    next_state = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid) begin
          next_state = SETUP;
          load       = 1'b1;
        end
      end
      SETUP:    next_state = REQ;
      REQ:      next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (AckA) begin
          if (bit_cnt == CNT_ONE) begin
            next_state = IDLE;
            finish     = 1'b1;
          end else begin
            next_state = SETUP;
            advance    = 1'b1;
          end
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (rstA) begin
      state       <= IDLE;
      DataA       <= 1'b0;
      ReqA        <= 1'b0;
      din_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      tcnt        <= '0;
    end else begin
      state     <= next_state;
      ReqA      <= (next_state == REQ);
      din_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      done      <= finish;

      if (load) begin
        shreg   <= din;
        bit_cnt <= WIDTH_CNT;
        DataA   <= first_load;
      end else if (advance) begin
        shreg   <= shift_next;
        bit_cnt <= bit_cnt - CNT_ONE;
        DataA   <= first_next;
      end

      if (state == REQ)
        tcnt <= '0;
      else if ((state == WAIT_ACK) && (tcnt != TMAX))
        tcnt <= tcnt + 16'd1;

      // A new error event takes priority over a simultaneous clear.
      if (proto_hit)
        proto_err <= 1'b1;
      else if (err_clr)
        proto_err <= 1'b0;

      if (timeout_hit)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

endmodule
